// File: rtl/adder_result_accumulator.sv
// Block accumulator for ripple-adder results: sums COUNT_N {carry, sum} operands,
// counts carries out of bit 15, and hands the block total downstream.
module adder_result_accumulator #(
  parameter int SUM_W   = 16,
  parameter int ACC_W   = 24,
  parameter int COUNT_N = 16,
  parameter int CNT_W   = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [SUM_W-1:0] sumIn,
  input  logic [3:0]       cOutIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [ACC_W-1:0] accOut,
  output logic [CNT_W-1:0] carryCount,
  output logic             accOverflow,
  output logic             fsm_state
);

  // Handshake rule for both ports: a transfer happens on a rising Clk edge where
  // valid and ready are both high; inReady and outValid are registered and
  // mutually exclusive, so input and output transfers never coincide.

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT_N - 1);

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   sum_next;

  // The adder's carry out of bit 15 is the operand's bit 16.
  always_comb begin
    operand  = {{(ACC_W - SUM_W){1'b0}}, cOutIn[3], sumIn};
    sum_next = {1'b0, accOut} + operand;
  end

  assign fsm_state = (state == DONE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= ACCUM;
      accOut      <= '0;
      sample_cnt  <= '0;
      carryCount  <= '0;
      accOverflow <= 1'b0;
      inReady     <= 1'b1;
      outValid    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (inValid) begin
            accOut      <= sum_next[ACC_W-1:0];
            accOverflow <= accOverflow | sum_next[ACC_W];
            carryCount  <= carryCount + CNT_W'(cOutIn[3]);
            sample_cnt  <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_IDX) begin
              state    <= DONE;
              inReady  <= 1'b0;
              outValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (outReady) begin
            state       <= ACCUM;
            accOut      <= '0;
            sample_cnt  <= '0;
            carryCount  <= '0;
            accOverflow <= 1'b0;
            inReady     <= 1'b1;
            outValid    <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: one 24-bit and one 20-bit instance share
// stimulus; table blocks, random blocks vs. an arithmetic model, and corner sequences.
module tb_adder_result_accumulator;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        inValid = 1'b0;
  logic [15:0] sumIn = '0;
  logic [3:0]  cOutIn = '0;
  logic        outReady = 1'b0;

  logic        in_ready_a, out_valid_a, ovf_a, state_a;
  logic [23:0] acc_a;
  logic [4:0]  cc_a;
  logic        in_ready_b, out_valid_b, ovf_b, state_b;
  logic [19:0] acc_b;
  logic [4:0]  cc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  adder_result_accumulator u_a (
    .Clk(Clk), .Rst(Rst), .inValid(inValid), .inReady(in_ready_a),
    .sumIn(sumIn), .cOutIn(cOutIn), .outValid(out_valid_a), .outReady(outReady),
    .accOut(acc_a), .carryCount(cc_a), .accOverflow(ovf_a), .fsm_state(state_a)
  );

  adder_result_accumulator #(.ACC_W(20)) u_b (
    .Clk(Clk), .Rst(Rst), .inValid(inValid), .inReady(in_ready_b),
    .sumIn(sumIn), .cOutIn(cOutIn), .outValid(out_valid_b), .outReady(outReady),
    .accOut(acc_b), .carryCount(cc_b), .accOverflow(ovf_b), .fsm_state(state_b)
  );

  typedef struct {
    logic [15:0] start;
    logic [15:0] step;
    logic [3:0]  cout;
    logic [23:0] exp_acc_a;
    logic        exp_ovf_a;
    logic [19:0] exp_acc_b;
    logic        exp_ovf_b;
    logic [4:0]  exp_cc;
  } block_vec_t;

  block_vec_t  table_v [4];
  logic [15:0] blk_s [16];
  logic [3:0]  blk_c [16];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic [3:0] c, input int gap);
    int budget;
    repeat (gap) tick();
    inValid = 1'b1;
    sumIn   = s;
    cOutIn  = c;
    budget  = 0;
    while (!in_ready_a && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready_a) cmp("push_timeout", 32'(in_ready_a), 32'd1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic push_block(input int max_gap);
    for (int i = 0; i < 16; i++) push(blk_s[i], blk_c[i], $urandom_range(0, max_gap));
  endtask

  // Checks the completed block on both instances, then accepts it.
  task automatic check_done(input string name, input logic [23:0] ea, input logic ova,
                            input logic [19:0] eb, input logic ovb, input logic [4:0] ecc);
    cmp({name, "_valid_a"}, 32'(out_valid_a), 32'd1);
    cmp({name, "_valid_b"}, 32'(out_valid_b), 32'd1);
    cmp({name, "_ready"},   32'(in_ready_a),  32'd0);
    cmp({name, "_acc_a"},   32'(acc_a), 32'(ea));
    cmp({name, "_ovf_a"},   32'(ovf_a), 32'(ova));
    cmp({name, "_acc_b"},   32'(acc_b), 32'(eb));
    cmp({name, "_ovf_b"},   32'(ovf_b), 32'(ovb));
    cmp({name, "_cc_a"},    32'(cc_a),  32'(ecc));
    cmp({name, "_cc_b"},    32'(cc_b),  32'(ecc));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    cmp({name, "_clr_valid"}, 32'(out_valid_a), 32'd0);
    cmp({name, "_clr_acc"},   32'(acc_a), 32'd0);
    cmp({name, "_clr_ovf_b"}, 32'(ovf_b), 32'd0);
    cmp({name, "_clr_ready"}, 32'(in_ready_a), 32'd1);
  endtask

  // Reference: the block total as plain integer arithmetic, reduced per width.
  task automatic model_check(input string name);
    longint total = 0;
    int     carries = 0;
    for (int i = 0; i < 16; i++) begin
      total   += longint'({blk_c[i][3], blk_s[i]});
      carries += int'(blk_c[i][3]);
    end
    check_done(name, 24'(total % (64'd1 << 24)), total >= (64'd1 << 24),
               20'(total % (64'd1 << 20)), total >= (64'd1 << 20), 5'(carries));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    table_v[0] = '{16'h0000, 16'h0100, 4'b0000, 24'h007800,  1'b0, 20'h07800, 1'b0, 5'd0};
    table_v[1] = '{16'hFFFF, 16'h0000, 4'b1000, 24'h1FFFF0,  1'b0, 20'hFFFF0, 1'b1, 5'd16};
    table_v[2] = '{16'h0000, 16'h0000, 4'b0111, 24'h000000,  1'b0, 20'h00000, 1'b0, 5'd0};
    table_v[3] = '{16'h0001, 16'h0000, 4'b0000, 24'h000010,  1'b0, 20'h00010, 1'b0, 5'd0};

    // Reset held with inValid high: nothing may be taken.
    inValid = 1'b1;
    sumIn   = 16'h1234;
    cOutIn  = 4'b1000;
    repeat (3) tick();
    cmp("rst_valid", 32'(out_valid_a), 32'd0);
    cmp("rst_acc",   32'(acc_a), 32'd0);
    cmp("rst_cc",    32'(cc_a), 32'd0);
    cmp("rst_ovf",   32'(ovf_a), 32'd0);
    inValid = 1'b0;
    Rst     = 1'b0;
    tick();
    cmp("rst_ready", 32'(in_ready_a), 32'd1);
    cmp("rst_acc2",  32'(acc_a), 32'd0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        blk_s[i] = table_v[t].start + 16'(i) * table_v[t].step;
        blk_c[i] = table_v[t].cout;
      end
      push_block(t == 3 ? 2 : 0);
      check_done($sformatf("table%0d", t), table_v[t].exp_acc_a, table_v[t].exp_ovf_a,
                 table_v[t].exp_acc_b, table_v[t].exp_ovf_b, table_v[t].exp_cc);
    end

    // Backpressure: the pending block is frozen and extra inputs are dropped.
    for (int i = 0; i < 16; i++) begin
      blk_s[i] = 16'h1000;
      blk_c[i] = 4'b1000;
    end
    push_block(0);
    for (int k = 0; k < 5; k++) begin
      inValid = k[0];
      sumIn   = 16'(($urandom));
      cOutIn  = 4'b1000;
      tick();
      cmp("bp_valid", 32'(out_valid_a), 32'd1);
      cmp("bp_ready", 32'(in_ready_a), 32'd0);
      cmp("bp_acc",   32'(acc_a), 32'h110000);
    end
    inValid = 1'b0;
    model_check("bp");
    for (int i = 0; i < 16; i++) begin
      blk_s[i] = 16'h0002;
      blk_c[i] = 4'b0000;
    end
    push_block(1);
    check_done("after_bp", 24'h000020, 1'b0, 20'h00020, 1'b0, 5'd0);

    // Reset mid-block discards the partial sum immediately.
    for (int i = 0; i < 7; i++) push(16'h0010, 4'b0000, 0);
    cmp("mid_partial", 32'(acc_a), 32'h70);
    Rst = 1'b1;
    #1;
    cmp("mid_async_acc", 32'(acc_a), 32'd0);
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      blk_s[i] = 16'h0001;
      blk_c[i] = 4'b0000;
    end
    push_block(3);
    check_done("mid_rst", 24'h000010, 1'b0, 20'h00010, 1'b0, 5'd0);

    // Reset while a block is pending: no handshake, back to ACCUM.
    push_block(0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    cmp("done_rst_valid", 32'(out_valid_a), 32'd0);
    cmp("done_rst_ready", 32'(in_ready_a), 32'd1);

    // Random blocks against the arithmetic model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        blk_s[i] = (r < 3) ? 16'($urandom_range(16'hE000, 16'hFFFF)) : 16'($urandom);
        blk_c[i] = 4'($urandom);
      end
      push_block(r % 3);
      model_check($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream consumer of the 16-bit four-stage ripple adder.
- Captures each adder result (sumFinal plus cOutFinal) through a valid/ready handshake.
- Accumulates a fixed block of COUNT_N results into a wide total and counts how many results carried out of bit 15.
- Presents the block total to the next stage with a valid/ready handshake, then clears for the next block.

Parameters:
- SUM_W, 16, width of the adder sum input.
- ACC_W, 24, accumulator / total output width (must be > SUM_W).
- COUNT_N, 16, results accumulated per block (≥ 1).
- CNT_W, 5, width of sample and carry counters (2^CNT_W > COUNT_N).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- inValid  in  1  sumIn/cOutIn hold a valid adder result.
- inReady  out  1  block can accept a result this cycle.
- sumIn  in  SUM_W  adder sumFinal.
- cOutIn  in  4  adder cOutFinal; bit 3 is the carry out of bit 15.
- outValid  out  1  accOut/carryCount/accOverflow hold a completed block.
- outReady  in  1  downstream accepts the block this cycle.
- accOut  out  ACC_W  block total, modulo 2^ACC_W.
- carryCount  out  CNT_W  number of results in the block with cOutIn[3]=1.
- accOverflow  out  1  block total exceeded 2^ACC_W-1 (sticky within the block).

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high on Rst.
- Reset, applied immediately:
  - state=ACCUM.
  - accumulator, sample counter, carryCount, accOverflow = 0.
  - outValid=0, accOut=0.
  - inReady=1 once state is ACCUM; no transfer is taken while Rst is high.
- Input transfer: inValid & inReady sampled at a rising Clk edge.
  - Operand value = {cOutIn[3], sumIn}, 17 bits, zero-extended to ACC_W+1.
  - cOutIn[2:0] are ignored.
- State ACCUM:
  - inReady=1, outValid=0.
  - On each transfer: acc <= acc + value (low ACC_W bits); accOverflow <= accOverflow | carry-out of bit ACC_W-1; carryCount += cOutIn[3]; sample counter += 1.
  - No transfer: all registers hold.
  - inValid gaps of any length are allowed.
  - The transfer that makes the sample count reach COUNT_N moves state to DONE on the same edge. The registers include that final sample.
- State DONE:
  - inReady=0, outValid=1.
  - accOut/carryCount/accOverflow stay stable until accepted; inValid is ignored.
  - On outValid & outReady at an edge: clear accumulator, counters and accOverflow, then return to ACCUM. inReady=1 the next cycle.
- Latency:
  - outValid rises in the cycle after the edge that accepted the COUNT_N-th result.
  - Minimum block period is COUNT_N+1 cycles with inValid=1 and outReady=1.
- accOut is the registered accumulator. It is valid only while outValid=1, but is visible in ACCUM as the running partial sum.
- Wrap-around:
  - The accumulator wraps modulo 2^ACC_W.
  - accOverflow records any wrap in the block and is cleared only by acceptance or reset.
- Rst asserted mid-block or while in DONE: the partial or pending block is discarded, with no output handshake.
- No simultaneous input and output transfer exists, because inReady=0 in DONE.

Test Plan:
1. Reset: assert Rst for 3 cycles, inValid=1 -> outValid=0, accOut=0, carryCount=0, accOverflow=0; inReady=1 after release; nothing accumulated.
2. Default params: 16 back-to-back results sumIn=0x0100*i (i=0..15), cOutIn=0, outReady=1 -> outValid high for one cycle, 1 cycle after the 16th transfer; accOut=0x007800, carryCount=0, accOverflow=0.
3. Carry path: 16 results sumIn=0xFFFF, cOutIn=4'b1000 -> accOut=0x1FFFF0, carryCount=16, accOverflow=0; cOutIn=4'b0111 with sumIn=0 -> adds 0.
4. Backpressure: complete a block with outReady=0 for 5 cycles while pulsing inValid -> outValid stays 1, accOut stable, inReady=0, extra inputs dropped; outReady=1 -> next block starts from 0.
5. Overflow, ACC_W=20: 16 results of 0xFFFF with carry -> accOut=0xFFFF0, accOverflow=1; next block of 16 results of 0x0001 -> accOut=0x00010, accOverflow=0.
6. Reset mid-block: 7 transfers of 0x0010, then a 1-cycle Rst pulse, then 16 transfers of 0x0001 with random inValid gaps -> accOut=0x000010, carryCount=0.
